// File: rtl/axil_led_mem_slave.sv
// ---------------------------------------------------------------------------
// axil_led_mem_slave
//
// AXI4-Lite responder for the PS7 GP0 master port. It holds a small array of
// 32-bit words: word 0 is the LED register, and words 1..NUM_WORDS-1 are
// scratch storage. The low LED_WIDTH bits of word 0 drive the board LEDs.
//
// Ports:
//   ACLK, ARESETn          : clock and asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W*   : write address and write data channels. They are
//                            accepted independently and may arrive in any order.
//   S_AXI_B*               : write response (OKAY, or SLVERR when out of range)
//   S_AXI_AR* / S_AXI_R*   : read address and read data channels
//   leds                   : word0[LED_WIDTH-1:0]
//
// The write path and the read path are separate two-state FSMs. Every output
// comes straight from a flop.
// ---------------------------------------------------------------------------
module axil_led_mem_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_WORDS  = 16,
  parameter int LED_WIDTH  = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [LED_WIDTH-1:0]  leds
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W:0] NUM_WORDS_C = (IDX_W + 1)'(NUM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // A word index is valid only if it is below NUM_WORDS. The 4 KB window
  // contains many more indices than there are implemented words.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < NUM_WORDS_C);
  endfunction

  // Merge the new data into the old word. Each byte lane is taken from the
  // new data only when its WSTRB bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0] mem_r [NUM_WORDS];

  // Write-path state
  w_state_t          w_state_r, w_state_n;
  logic              aw_held_r, aw_held_n;
  logic              w_held_r, w_held_n;
  logic [IDX_W-1:0]  awidx_r, awidx_n;
  logic [31:0]       wdata_r, wdata_n;
  logic [3:0]        wstrb_r, wstrb_n;
  logic              awready_r, awready_n;
  logic              wready_r, wready_n;
  logic              bvalid_r, bvalid_n;
  logic [1:0]        bresp_r, bresp_n;

  // Read-path state
  r_state_t          r_state_r, r_state_n;
  logic              arready_r, arready_n;
  logic              rvalid_r, rvalid_n;
  logic [31:0]       rdata_r, rdata_n;
  logic [1:0]        rresp_r, rresp_n;

  // Write-commit controls, combinational
  logic              wr_en_s;
  logic [MEM_AW-1:0] wr_idx_s;
  logic [31:0]       wr_word_s;
  logic              aw_hs_s, w_hs_s, aw_have_s, w_have_s;
  logic [IDX_W-1:0]  cur_awidx_s, cur_aridx_s;
  logic [31:0]       cur_wdata_s;
  logic [3:0]        cur_wstrb_s;

  // Bits [1:0] of each address select a byte within a word. They do not
  // select anything here.
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write-path next-state logic: independent AW and W capture, commit, and response hold
  always_comb begin
    w_state_n   = w_state_r;
    aw_held_n   = aw_held_r;
    w_held_n    = w_held_r;
    awidx_n     = awidx_r;
    wdata_n     = wdata_r;
    wstrb_n     = wstrb_r;
    awready_n   = awready_r;
    wready_n    = wready_r;
    bvalid_n    = bvalid_r;
    bresp_n     = bresp_r;
    wr_en_s     = 1'b0;
    wr_idx_s    = '0;
    wr_word_s   = 32'h0000_0000;
    aw_hs_s     = S_AXI_AWVALID & awready_r;
    w_hs_s      = S_AXI_WVALID & wready_r;
    aw_have_s   = aw_held_r | aw_hs_s;
    w_have_s    = w_held_r | w_hs_s;
    // Use the held copy if one exists; otherwise use the value on the bus
    // in this cycle.
    cur_awidx_s = aw_held_r ? awidx_r : S_AXI_AWADDR[ADDR_WIDTH-1:2];
    cur_wdata_s = w_held_r ? wdata_r : S_AXI_WDATA;
    cur_wstrb_s = w_held_r ? wstrb_r : S_AXI_WSTRB;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s) begin
          aw_held_n = 1'b1;
          awidx_n   = S_AXI_AWADDR[ADDR_WIDTH-1:2];
        end else begin
          aw_held_n = aw_held_r;
        end
        if (w_hs_s) begin
          w_held_n = 1'b1;
          wdata_n  = S_AXI_WDATA;
          wstrb_n  = S_AXI_WSTRB;
        end else begin
          w_held_n = w_held_r;
        end
        if (aw_have_s && w_have_s) begin
          // Commit on this edge. An out-of-range index writes nothing and
          // answers SLVERR.
          wr_en_s   = idx_in_range(cur_awidx_s);
          wr_idx_s  = cur_awidx_s[MEM_AW-1:0];
          wr_word_s = merge_bytes(mem_r[cur_awidx_s[MEM_AW-1:0]], cur_wdata_s, cur_wstrb_s);
          bresp_n   = idx_in_range(cur_awidx_s) ? RESP_OKAY : RESP_SLVERR;
          bvalid_n  = 1'b1;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          w_state_n = W_RESP;
        end else begin
          awready_n = ~aw_have_s;
          wready_n  = ~w_have_s;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_n  = 1'b0;
          bresp_n   = RESP_OKAY;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          w_state_n = W_IDLE;
        end else begin
          bvalid_n  = 1'b1;
          awready_n = 1'b0;
          wready_n  = 1'b0;
        end
      end
      default: begin
        w_state_n = W_IDLE;
        bvalid_n  = 1'b0;
        awready_n = 1'b0;
        wready_n  = 1'b0;
      end
    endcase
  end

  // Write-path state registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_r <= W_IDLE;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      awidx_r   <= '0;
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'h0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      w_state_r <= w_state_n;
      aw_held_r <= aw_held_n;
      w_held_r  <= w_held_n;
      awidx_r   <= awidx_n;
      wdata_r   <= wdata_n;
      wstrb_r   <= wstrb_n;
      awready_r <= awready_n;
      wready_r  <= wready_n;
      bvalid_r  <= bvalid_n;
      bresp_r   <= bresp_n;
    end
  end

  // Word storage. A read that shares an edge with a write sees the old value,
  // because the non-blocking update lands only after that edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (wr_en_s) begin
      mem_r[wr_idx_s] <= wr_word_s;
    end else begin
      mem_r[0] <= mem_r[0];
    end
  end

  // Read-path next-state logic: capture data on the AR handshake and hold it until RREADY
  always_comb begin
    r_state_n   = r_state_r;
    arready_n   = arready_r;
    rvalid_n    = rvalid_r;
    rdata_n     = rdata_r;
    rresp_n     = rresp_r;
    cur_aridx_s = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    case (r_state_r)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_r) begin
          if (idx_in_range(cur_aridx_s)) begin
            rdata_n = mem_r[cur_aridx_s[MEM_AW-1:0]];
            rresp_n = RESP_OKAY;
          end else begin
            rdata_n = 32'h0000_0000;
            rresp_n = RESP_SLVERR;
          end
          rvalid_n  = 1'b1;
          arready_n = 1'b0;
          r_state_n = R_DATA;
        end else begin
          arready_n = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          r_state_n = R_IDLE;
        end else begin
          rvalid_n  = 1'b1;
          arready_n = 1'b0;
        end
      end
      default: begin
        r_state_n = R_IDLE;
        rvalid_n  = 1'b0;
        arready_n = 1'b0;
      end
    endcase
  end

  // Read-path state registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h0000_0000;
      rresp_r   <= RESP_OKAY;
    end else begin
      r_state_r <= r_state_n;
      arready_r <= arready_n;
      rvalid_r  <= rvalid_n;
      rdata_r   <= rdata_n;
      rresp_r   <= rresp_n;
    end
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign leds          = mem_r[0][LED_WIDTH-1:0];

endmodule

// File: tb/tb_axil_led_mem_slave.sv
// ---------------------------------------------------------------------------
// Testbench for axil_led_mem_slave, using the default parameters
// (12-bit address, 16 words, 4 LEDs). A behavioural array model predicts
// every response, and directed and random AXI-Lite transactions are compared
// against it.
// ---------------------------------------------------------------------------
module tb_axil_led_mem_slave;

  logic        tb_ACLK;
  logic        tb_ARESETn;
  logic [11:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [11:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [3:0]  leds;

  int vectors;
  int miscompares;

  // Reference model: one 32-bit entry per implemented word
  logic [31:0] model_mem [16];

  axil_led_mem_slave #(.ADDR_WIDTH(12), .NUM_WORDS(16), .LED_WIDTH(4)) dut (
    .ACLK(tb_ACLK), .ARESETn(tb_ARESETn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .leds(leds)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: handshake timeout", tag);
  endtask

  function automatic logic model_in_range(input logic [11:0] addr);
    return (int'(addr) / 4) < 16;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] addr);
    if (model_in_range(addr)) return model_mem[int'(addr) / 4];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr) / 4;
    if (idx < 16) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
  endtask

  // AW and W presented together with BREADY high. The task checks the
  // response and the LEDs on the commit edge, then checks that BVALID drops
  // one edge later.
  task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic aw_done, w_done, aw_fire, w_fire;
    int n;
    @(negedge tb_ACLK);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_fire = awvalid & awready;
      w_fire  = wvalid & wready;
      @(posedge tb_ACLK); #1;
      if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_fire)  begin wvalid  = 1'b0; w_done  = 1'b1; end
      n++;
      if (!(aw_done && w_done)) @(negedge tb_ACLK);
    end
    if (!(aw_done && w_done)) begin
      awvalid = 1'b0; wvalid = 1'b0;
      timeout_fail("wr_handshake");
      return;
    end
    model_write(addr, data, strb);
    chk("wr_bvalid", 32'(bvalid), 32'd1);
    chk("wr_bresp", 32'(bresp), model_in_range(addr) ? 32'd0 : 32'd2);
    chk("wr_leds", 32'(leds), 32'(model_mem[0][3:0]));
    @(posedge tb_ACLK); #1;
    chk("wr_bvalid_drop", 32'(bvalid), 32'd0);
  endtask

  // AR presented with RREADY high. The task checks the data and response on
  // the handshake edge.
  task automatic do_read(input logic [11:0] addr);
    logic done, fire;
    int n;
    @(negedge tb_ACLK);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      fire = arvalid & arready;
      @(posedge tb_ACLK); #1;
      if (fire) begin arvalid = 1'b0; done = 1'b1; end
      n++;
      if (!done) @(negedge tb_ACLK);
    end
    if (!done) begin
      arvalid = 1'b0;
      timeout_fail("rd_handshake");
      return;
    end
    chk("rd_rvalid", 32'(rvalid), 32'd1);
    chk("rd_rdata", rdata, model_read(addr));
    chk("rd_rresp", 32'(rresp), model_in_range(addr) ? 32'd0 : 32'd2);
    @(posedge tb_ACLK); #1;
    chk("rd_rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_old;
    logic [11:0] ra;
    vectors = 0; miscompares = 0;
    model_clear();
    tb_ARESETn = 1'b0;
    awaddr = 12'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
    araddr = 12'h0; arvalid = 1'b0; rready = 1'b0;

    // Behaviour while reset is held
    repeat (3) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    tb_ARESETn = 1'b1;
    @(posedge tb_ACLK); #1;
    chk("post_rst_awready", 32'(awready), 32'd1);
    chk("post_rst_wready", 32'(wready), 32'd1);
    chk("post_rst_arready", 32'(arready), 32'd1);

    // LED register: full write
    do_write(12'h000, 32'hFFFF_FFFF, 4'hF);
    chk("leds_all_on", 32'(leds), 32'hF);

    // Scratch word round trip
    do_write(12'h004, 32'hDEAD_BEEF, 4'hF);
    do_read(12'h004);

    // Byte strobes: 0x11223344 then 0xAABBCCDD with WSTRB=0x5
    do_write(12'h008, 32'h1122_3344, 4'hF);
    do_write(12'h008, 32'hAABB_CCDD, 4'h5);
    do_read(12'h008);
    chk("strobe_merge", rdata, 32'h11BB_33DD);

    // W three cycles before AW; BREADY held low for 4 cycles
    @(negedge tb_ACLK);
    awaddr = 12'h00C; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    chk("wfirst_wready", 32'(wready), 32'd1);
    @(posedge tb_ACLK); #1;
    wvalid = 1'b0;
    repeat (3) begin
      @(negedge tb_ACLK);
      chk("wheld_wready", 32'(wready), 32'd0);
      chk("wheld_awready", 32'(awready), 32'd1);
      chk("wheld_bvalid", 32'(bvalid), 32'd0);
    end
    awvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0;
    model_write(12'h00C, 32'hCAFE_F00D, 4'hF);
    chk("late_aw_bvalid", 32'(bvalid), 32'd1);
    chk("late_aw_bresp", 32'(bresp), 32'd0);
    repeat (4) begin
      @(negedge tb_ACLK);
      chk("bstall_bvalid", 32'(bvalid), 32'd1);
      chk("bstall_awready", 32'(awready), 32'd0);
      chk("bstall_wready", 32'(wready), 32'd0);
    end
    bready = 1'b1;
    @(posedge tb_ACLK); #1;
    chk("bstall_release_bvalid", 32'(bvalid), 32'd0);
    chk("bstall_release_awready", 32'(awready), 32'd1);
    chk("bstall_release_wready", 32'(wready), 32'd1);
    do_read(12'h00C);

    // Out-of-range word index 16
    do_write(12'h040, 32'h1234_5678, 4'hF);
    do_read(12'h040);
    do_read(12'h000);
    chk("oor_leds_kept", 32'(leds), 32'hF);

    // Write commit and read of word 0 on the same edge
    @(negedge tb_ACLK);
    awaddr = 12'h000; awvalid = 1'b1; wdata = 32'h0000_0005; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 12'h000; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    chk("same_awready", 32'(awready), 32'd1);
    chk("same_arready", 32'(arready), 32'd1);
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp_old = model_mem[0];
    model_write(12'h000, 32'h0000_0005, 4'hF);
    chk("same_rvalid", 32'(rvalid), 32'd1);
    chk("same_rdata_old", rdata, exp_old);
    chk("same_bvalid", 32'(bvalid), 32'd1);
    chk("same_leds_new", 32'(leds), 32'h5);
    @(posedge tb_ACLK); #1;
    do_read(12'h000);
    chk("same_leds_after", 32'(leds), 32'h5);

    // Random accesses over the window. Some land beyond the last word.
    for (int it = 0; it < 40; it++) begin
      ra = 12'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        do_write(ra, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        do_read(ra);
      end
    end

    // Reset asserted asynchronously with a response pending
    @(negedge tb_ACLK);
    awaddr = 12'h000; awvalid = 1'b1; wdata = 32'h0000_000A; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b0;
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pre_rst_leds", 32'(leds), 32'hA);
    #2 tb_ARESETn = 1'b0;
    #1;
    model_clear();
    chk("midrst_bvalid", 32'(bvalid), 32'd0);
    chk("midrst_leds", 32'(leds), 32'h0);
    chk("midrst_awready", 32'(awready), 32'd0);
    @(negedge tb_ACLK);
    tb_ARESETn = 1'b1;
    @(posedge tb_ACLK); #1;
    chk("midrst_no_bvalid", 32'(bvalid), 32'd0);
    chk("midrst_awready_back", 32'(awready), 32'd1);
    do_read(12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
